// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture block: FSM encoding and sizing helpers.
package scope_pkg;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StPretrig = 3'd1;
  localparam logic [2:0] StArmed   = 3'd2;
  localparam logic [2:0] StPost    = 3'd3;
  localparam logic [2:0] StDump    = 3'd4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((64'd1 << result) < 64'(value)) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic int unsigned bytes_per_sample(input int unsigned width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/scope_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port with read enable.
module scope_ram
  import scope_pkg::*;
#(
  parameter int unsigned pDataWidth = 8,
  parameter int unsigned pDepth     = 256
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [clog2(pDepth)-1:0]   waddr_i,
  input  logic [pDataWidth-1:0]      wdata_i,
  input  logic                       re_i,
  input  logic [clog2(pDepth)-1:0]   raddr_i,
  output logic [pDataWidth-1:0]      rdata_o
);

  logic [pDataWidth-1:0] mem_q [pDepth];
  logic [pDataWidth-1:0] rdata_q;

  // Read data only advances on re_i, so rdata_o doubles as the readout prefetch slot.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_capture.sv
// Decimating circular-buffer scope with pre-trigger window, edge/force trigger
// and byte-wise valid/ready replay of the captured frame.
module scope_capture
  import scope_pkg::*;
#(
  parameter int unsigned pDataWidth  = 8,
  parameter int unsigned pDepth      = 256,
  parameter int unsigned pDecimWidth = 16
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic [pDataWidth-1:0]      iData,
  input  logic                       iData_Valid,
  input  logic                       iArm,
  input  logic [pDataWidth-1:0]      iTrigLevel,
  input  logic                       iTrigRising,
  input  logic                       iTrigForce,
  input  logic [pDecimWidth-1:0]     iDecim,
  input  logic [clog2(pDepth)-1:0]   iPreTrig,
  output logic [7:0]                 oData,
  output logic                       oData_Valid,
  input  logic                       iData_Ready,
  output logic                       oBusy,
  output logic                       oTriggered,
  output logic                       oDone
);

  localparam int unsigned Aw   = clog2(pDepth);
  localparam int unsigned CntW = Aw + 1;
  localparam int unsigned Bps  = bytes_per_sample(pDataWidth);
  localparam logic [Aw-1:0]   LastAddr = Aw'(pDepth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(pDepth);

  logic [2:0]             state_q, state_d;
  logic [pDecimWidth-1:0] decim_q, decim_d, dcnt_q, dcnt_d;
  logic [pDataWidth-1:0]  level_q, level_d, prev_q, prev_d, obuf_q, obuf_d;
  logic                   rising_q, rising_d, have_prev_q, have_prev_d;
  logic                   force_q, force_d, trig_q, trig_d, done_q, done_d;
  logic                   pv_q, pv_d, ov_q, ov_d, bidx_q, bidx_d;
  logic [Aw-1:0]          pretrig_q, pretrig_d, fill_q, fill_d, wr_ptr_q, wr_ptr_d;
  logic [Aw-1:0]          post_q, post_d, rd_addr_q, rd_addr_d;
  logic [CntW-1:0]        rd_cnt_q, rd_cnt_d;

  logic                   capturing, keep, edge_hit, trig_hit;
  logic                   fire, last_byte, load_out, rd_left, re, final_xfer;
  logic [pDataWidth-1:0]  ram_rdata;
  logic [15:0]            obuf_pad;

  assign capturing = (state_q == StPretrig) || (state_q == StArmed) || (state_q == StPost);
  assign keep      = capturing && iData_Valid && (dcnt_q == '0);
  assign edge_hit  = have_prev_q && (rising_q ? (prev_q < level_q && iData >= level_q)
                                              : (prev_q > level_q && iData <= level_q));
  assign trig_hit  = keep && (state_q == StArmed) && (force_q || iTrigForce || edge_hit);

  // Two-slot readout: RAM output register is the prefetch slot, obuf_q the output slot.
  assign fire       = ov_q && iData_Ready;
  assign last_byte  = (bidx_q == 1'(Bps - 1));
  assign load_out   = pv_q && (!ov_q || (fire && last_byte));
  assign rd_left    = (rd_cnt_q != DepthCnt);
  assign re         = (state_q == StDump) && rd_left && (!pv_q || load_out);
  assign final_xfer = (state_q == StDump) && fire && last_byte && !pv_q && !rd_left;

  always_comb begin
    state_d     = state_q;
    decim_d     = decim_q;
    dcnt_d      = dcnt_q;
    level_d     = level_q;
    rising_d    = rising_q;
    pretrig_d   = pretrig_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    force_d     = force_q;
    post_d      = post_q;
    rd_addr_d   = rd_addr_q;
    rd_cnt_d    = rd_cnt_q;
    pv_d        = pv_q;
    ov_d        = ov_q;
    obuf_d      = obuf_q;
    bidx_d      = bidx_q;
    trig_d      = trig_q;
    done_d      = 1'b0;

    if (capturing && iData_Valid) begin
      dcnt_d = (dcnt_q == '0) ? decim_q : dcnt_q - pDecimWidth'(1);
    end
    if (keep) begin
      wr_ptr_d    = wr_ptr_q + Aw'(1);
      prev_d      = iData;
      have_prev_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (iArm) begin
          decim_d     = iDecim;
          level_d     = iTrigLevel;
          rising_d    = iTrigRising;
          pretrig_d   = iPreTrig;
          dcnt_d      = '0;
          fill_d      = '0;
          have_prev_d = 1'b0;
          force_d     = 1'b0;
          rd_cnt_d    = '0;
          pv_d        = 1'b0;
          ov_d        = 1'b0;
          bidx_d      = 1'b0;
          state_d     = (iPreTrig == '0) ? StArmed : StPretrig;
        end
      end
      StPretrig: begin
        if (keep) begin
          fill_d = fill_q + Aw'(1);
          if (fill_q + Aw'(1) == pretrig_q) state_d = StArmed;
        end
      end
      StArmed: begin
        if (iTrigForce) force_d = 1'b1;
        if (trig_hit) begin
          trig_d    = 1'b1;
          force_d   = 1'b0;
          post_d    = LastAddr - pretrig_q;
          rd_addr_d = wr_ptr_q - pretrig_q;
          state_d   = (LastAddr == pretrig_q) ? StDump : StPost;
        end
      end
      StPost: begin
        if (keep) begin
          post_d = post_q - Aw'(1);
          if (post_q == Aw'(1)) state_d = StDump;
        end
      end
      StDump: begin
        if (re) begin
          rd_addr_d = rd_addr_q + Aw'(1);
          rd_cnt_d  = rd_cnt_q + CntW'(1);
          pv_d      = 1'b1;
        end else if (load_out) begin
          pv_d = 1'b0;
        end
        if (load_out) begin
          obuf_d = ram_rdata;
          ov_d   = 1'b1;
          bidx_d = 1'b0;
        end else if (fire) begin
          if (last_byte) ov_d = 1'b0;
          else           bidx_d = 1'b1;
        end
        if (final_xfer) begin
          state_d = StIdle;
          trig_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q     <= StIdle;
      decim_q     <= '0;
      dcnt_q      <= '0;
      level_q     <= '0;
      rising_q    <= 1'b0;
      pretrig_q   <= '0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      force_q     <= 1'b0;
      post_q      <= '0;
      rd_addr_q   <= '0;
      rd_cnt_q    <= '0;
      pv_q        <= 1'b0;
      ov_q        <= 1'b0;
      obuf_q      <= '0;
      bidx_q      <= 1'b0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      decim_q     <= decim_d;
      dcnt_q      <= dcnt_d;
      level_q     <= level_d;
      rising_q    <= rising_d;
      pretrig_q   <= pretrig_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      force_q     <= force_d;
      post_q      <= post_d;
      rd_addr_q   <= rd_addr_d;
      rd_cnt_q    <= rd_cnt_d;
      pv_q        <= pv_d;
      ov_q        <= ov_d;
      obuf_q      <= obuf_d;
      bidx_q      <= bidx_d;
      trig_q      <= trig_d;
      done_q      <= done_d;
    end
  end

  scope_ram #(
    .pDataWidth (pDataWidth),
    .pDepth     (pDepth)
  ) u_ram (
    .clk_i   (iClk),
    .we_i    (keep),
    .waddr_i (wr_ptr_q),
    .wdata_i (iData),
    .re_i    (re),
    .raddr_i (rd_addr_q),
    .rdata_o (ram_rdata)
  );

  assign obuf_pad    = 16'(obuf_q);
  assign oData       = bidx_q ? obuf_pad[15:8] : obuf_pad[7:0];
  assign oData_Valid = ov_q;
  assign oBusy       = (state_q != StIdle);
  assign oTriggered  = trig_q;
  assign oDone       = done_q;

endmodule

// File: tb/tb_scope_capture.sv
// Directed bench for scope_capture: 8-bit/256-deep instance plus a 12-bit/16-deep instance.
module tb_scope_capture;

  logic clk;
  logic rst;

  logic [7:0]  a_data, a_level, a_pre, a_odata;
  logic [15:0] a_decim;
  logic        a_valid, a_arm, a_rising, a_force, a_ready;
  logic        a_ovalid, a_busy, a_trig, a_done;

  logic [11:0] b_data, b_level;
  logic [15:0] b_decim;
  logic [3:0]  b_pre;
  logic [7:0]  b_odata;
  logic        b_valid, b_arm, b_rising, b_force, b_ready;
  logic        b_ovalid, b_busy, b_trig, b_done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_a[$];
  logic [7:0] rx_b[$];
  int done_a = 0, done_b = 0, gap_a = 0, stall_err = 0;
  logic done_trig = 1'b1, done_busy = 1'b1, trig_prev = 1'b0;
  logic b_hold = 1'b0;
  logic [7:0] b_held = 8'h00;

  scope_capture #(.pDataWidth(8), .pDepth(256), .pDecimWidth(16)) dut_a (
    .iClk(clk), .iRst(rst), .iData(a_data), .iData_Valid(a_valid), .iArm(a_arm),
    .iTrigLevel(a_level), .iTrigRising(a_rising), .iTrigForce(a_force), .iDecim(a_decim),
    .iPreTrig(a_pre), .oData(a_odata), .oData_Valid(a_ovalid), .iData_Ready(a_ready),
    .oBusy(a_busy), .oTriggered(a_trig), .oDone(a_done)
  );

  scope_capture #(.pDataWidth(12), .pDepth(16), .pDecimWidth(16)) dut_b (
    .iClk(clk), .iRst(rst), .iData(b_data), .iData_Valid(b_valid), .iArm(b_arm),
    .iTrigLevel(b_level), .iTrigRising(b_rising), .iTrigForce(b_force), .iDecim(b_decim),
    .iPreTrig(b_pre), .oData(b_odata), .oData_Valid(b_ovalid), .iData_Ready(b_ready),
    .oBusy(b_busy), .oTriggered(b_trig), .oDone(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors sample on the falling edge, half a cycle away from DUT updates.
  always @(negedge clk) begin
    if (a_ovalid && a_ready) rx_a.push_back(a_odata);
    if (a_done) begin
      done_a    <= done_a + 1;
      done_trig <= a_trig;
      done_busy <= a_busy;
    end
    if (trig_prev && !a_trig && !a_done && !rst) gap_a <= gap_a + 1;
    trig_prev <= a_trig;
  end

  always @(negedge clk) begin
    if (b_ovalid && b_ready) rx_b.push_back(b_odata);
    if (b_done) done_b <= done_b + 1;
    if (b_hold && !(b_ovalid && b_odata == b_held)) stall_err <= stall_err + 1;
    b_hold <= b_ovalid && !b_ready;
    b_held <= b_odata;
  end

  initial begin
    int phase = 0;
    b_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      phase   = (phase == 2) ? 0 : phase + 1;
      b_ready = (phase == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_a(input logic [15:0] decim, input logic [7:0] level, input logic rising,
                       input logic [7:0] pre);
    a_decim  = decim;
    a_level  = level;
    a_rising = rising;
    a_pre    = pre;
    a_arm    = 1'b1;
    tick();
    a_arm    = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] v);
    a_data  = v;
    a_valid = 1'b1;
    tick();
  endtask

  task automatic wait_done_a(input string tag, input int base, input int bound);
    for (int i = 0; i < bound && done_a == base; i++) tick();
    repeat (4) tick();
    check_val({tag, "_done_count"}, 32'(done_a - base), 32'd1);
  endtask

  task automatic check_frame_a(input string tag, input int base, input int first, input int step);
    int err = 0;
    check_val({tag, "_len"}, 32'(rx_a.size() - base), 32'd256);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] e;
      e = 8'(first + step * i);
      if (base + i >= rx_a.size()) err++;
      else if (rx_a[base + i] !== e) err++;
    end
    check_val({tag, "_frame_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int b0, d0;
    logic [7:0] pat5 [4];
    pat5 = '{8'hBC, 8'h0A, 8'h23, 8'h01};

    rst = 1'b1;
    a_data = '0; a_valid = 0; a_arm = 0; a_level = '0; a_rising = 0; a_force = 0;
    a_decim = '0; a_pre = '0; a_ready = 1'b1;
    b_data = '0; b_valid = 0; b_arm = 0; b_level = '0; b_rising = 0; b_force = 0;
    b_decim = '0; b_pre = '0;
    repeat (3) tick();
    check_val("rst_odata", 32'(a_odata), 32'd0);
    check_val("rst_ovalid", 32'(a_ovalid), 32'd0);
    check_val("rst_busy", 32'(a_busy), 32'd0);
    check_val("rst_trig", 32'(a_trig), 32'd0);
    check_val("rst_done", 32'(a_done), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: ramp, rising through 100, 16 pre-trigger samples.
    b0 = rx_a.size(); d0 = done_a;
    arm_a(16'd0, 8'd100, 1'b1, 8'd16);
    check_val("t1_busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 400; i++) send_a(8'(i));
    a_valid = 1'b0;
    wait_done_a("t1", d0, 2000);
    check_val("t1_byte0", 32'(rx_a[b0]), 32'd84);
    check_val("t1_byte16", 32'(rx_a[b0 + 16]), 32'd100);
    check_val("t1_byte255", 32'(rx_a[b0 + 255]), 32'd83);
    check_frame_a("t1", b0, 84, 1);
    check_val("t1_idle", 32'(a_busy), 32'd0);

    // Test 2: keep every 4th sample.
    b0 = rx_a.size(); d0 = done_a;
    arm_a(16'd3, 8'd100, 1'b1, 8'd4);
    for (int i = 0; i < 1200; i++) send_a(8'(i));
    a_valid = 1'b0;
    wait_done_a("t2", d0, 2000);
    check_val("t2_byte0", 32'(rx_a[b0]), 32'd84);
    check_val("t2_byte4", 32'(rx_a[b0 + 4]), 32'd100);
    check_frame_a("t2", b0, 84, 4);

    // Test 3: falling ramp through 50.
    b0 = rx_a.size(); d0 = done_a;
    arm_a(16'd0, 8'd50, 1'b0, 8'd8);
    for (int i = 0; i < 500; i++) send_a(8'(255 - i));
    a_valid = 1'b0;
    wait_done_a("t3", d0, 2000);
    check_val("t3_byte0", 32'(rx_a[b0]), 32'd58);
    check_val("t3_byte8", 32'(rx_a[b0 + 8]), 32'd50);
    check_frame_a("t3", b0, 58, 255);

    // Test 4: constant input, forced trigger, no pre-trigger window.
    b0 = rx_a.size(); d0 = done_a;
    arm_a(16'd0, 8'd200, 1'b1, 8'd0);
    for (int i = 0; i < 10; i++) send_a(8'h55);
    a_valid = 1'b0;
    check_val("t4_no_trig", 32'(a_trig), 32'd0);
    a_force = 1'b1;
    tick();
    a_force = 1'b0;
    send_a(8'h55);
    check_val("t4_trig", 32'(a_trig), 32'd1);
    for (int i = 0; i < 300; i++) send_a(8'h55);
    a_valid = 1'b0;
    wait_done_a("t4", d0, 2000);
    check_frame_a("t4", b0, 8'h55, 0);
    check_val("t4_done_trig", 32'(done_trig), 32'd0);
    check_val("t4_done_busy", 32'(done_busy), 32'd0);

    // Test 5: 12-bit samples, ready one cycle in three.
    b0 = rx_b.size(); d0 = done_b;
    b_arm = 1'b1;
    tick();
    b_arm = 1'b0;
    b_force = 1'b1;
    tick();
    b_force = 1'b0;
    for (int i = 0; i < 40; i++) begin
      b_data  = (i % 2 == 0) ? 12'hABC : 12'h123;
      b_valid = 1'b1;
      tick();
    end
    b_valid = 1'b0;
    for (int i = 0; i < 500 && done_b == d0; i++) tick();
    repeat (4) tick();
    check_val("t5_done_count", 32'(done_b - d0), 32'd1);
    check_val("t5_len", 32'(rx_b.size() - b0), 32'd32);
    check_val("t5_byte0", 32'(rx_b[b0]), 32'hBC);
    check_val("t5_byte1", 32'(rx_b[b0 + 1]), 32'h0A);
    check_val("t5_byte2", 32'(rx_b[b0 + 2]), 32'h23);
    check_val("t5_byte3", 32'(rx_b[b0 + 3]), 32'h01);
    begin
      int err = 0;
      for (int i = 0; i < 32; i++) begin
        if (b0 + i >= rx_b.size()) err++;
        else if (rx_b[b0 + i] !== pat5[i % 4]) err++;
      end
      check_val("t5_frame_err", 32'(err), 32'd0);
    end
    check_val("t5_stall_stable", 32'(stall_err), 32'd0);

    // Test 6: reset mid-POST, then arm ignored during DUMP.
    arm_a(16'd0, 8'd100, 1'b1, 8'd16);
    for (int i = 0; i < 150; i++) send_a(8'(i));
    a_valid = 1'b0;
    check_val("t6_post_busy", 32'(a_busy), 32'd1);
    check_val("t6_post_trig", 32'(a_trig), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_rst_busy", 32'(a_busy), 32'd0);
    check_val("t6_rst_trig", 32'(a_trig), 32'd0);
    check_val("t6_rst_ovalid", 32'(a_ovalid), 32'd0);
    check_val("t6_rst_odata", 32'(a_odata), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    b0 = rx_a.size(); d0 = done_a;
    check_val("t6_no_done", 32'(done_a), 32'(d0));
    a_ready = 1'b0;
    arm_a(16'd0, 8'd100, 1'b1, 8'd16);
    for (int i = 0; i < 400; i++) send_a(8'(i));
    a_valid = 1'b0;
    check_val("t6_dump_busy", 32'(a_busy), 32'd1);
    arm_a(16'd5, 8'd7, 1'b0, 8'd0);
    a_ready = 1'b1;
    wait_done_a("t6", d0, 2000);
    check_val("t6_byte0", 32'(rx_a[b0]), 32'd84);
    check_frame_a("t6", b0, 84, 1);

    check_val("trig_gap", 32'(gap_a), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
